rx_edge_monitor: RTL and testbench

RX_EDGE_MONITOR -- requirements
Module: rx_edge_monitor

---
 rtl/rx_edge_pkg.sv | 36 +++
 rtl/rx_edge_chan.sv | 86 ++++++++
 rtl/rx_edge_monitor.sv | 53 +++++
 tb/tb_rx_edge_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_edge_pkg.sv
// Shared types and default constants for the RX line edge monitor.
//   edge_mode_t   : per-channel edge qualification mode
//   DEF_*         : default parameter values used by rx_edge_monitor
//   qualify()     : turns a raw filtered-level change into a qualified edge
package rx_edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_ANY  = 2'b11
    } edge_mode_t;

    localparam int unsigned DEF_NUM_CH      = 2;
    localparam int unsigned DEF_SYNC_STAGES = 2;   // legal 2..4
    localparam int unsigned DEF_FILT_CYCLES = 3;   // legal 1..15
    localparam int unsigned DEF_CNT_W       = 8;
    localparam logic [1:0]  DEF_IDLE_VAL    = 2'b01; // D+ idles 1, D- idles 0

    // Wide enough for a filter count up to FILT_CYCLES-1 = 14.
    localparam int unsigned FILT_CNT_W = 4;

    function automatic logic qualify(input edge_mode_t mode,
                                     input logic       filt,
                                     input logic       prev);
        logic raw;
        raw = filt ^ prev;
        case (mode)
            EDGE_RISE: qualify = raw & filt;
            EDGE_FALL: qualify = raw & ~filt;
            EDGE_ANY:  qualify = raw;
            default:   qualify = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rx_edge_chan.sv
// One channel of the RX edge monitor: input synchronizer, glitch filter,
// edge qualification, sticky flag and saturating edge counter.
//   clk, n_rst   : clock, asynchronous active-low reset
//   d_in         : raw asynchronous line input
//   edge_mode    : 00 off, 01 rise, 10 fall, 11 any
//   clr          : write-1-to-clear for edge_sticky / edge_cnt
//   filt_out     : synchronized, filtered line level
//   d_edge       : one-cycle qualified edge pulse (combinational)
//   edge_sticky  : set on qualified edge, held until clr
//   edge_cnt     : saturating qualified-edge count
module rx_edge_chan
    import rx_edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter logic        IDLE_BIT    = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_in,
    input  logic [1:0]       edge_mode,
    input  logic             clr,
    output logic             filt_out,
    output logic             d_edge,
    output logic             edge_sticky,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [FILT_CNT_W-1:0] FILT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [FILT_CNT_W-1:0]  filt_cnt;
    logic                   filt_prev;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= {SYNC_STAGES{IDLE_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Level changes only after FILT_CYCLES consecutive mismatching samples;
    // any matching sample restarts the count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            filt_cnt  <= '0;
            filt_out  <= IDLE_BIT;
            filt_prev <= IDLE_BIT;
        end else begin
            filt_prev <= filt_out;
            if (sync == filt_out) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_out <= sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign d_edge = qualify(edge_mode_t'(edge_mode), filt_out, filt_prev);

    // A clear coinciding with an edge keeps that edge so none is lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            edge_sticky <= 1'b0;
            edge_cnt    <= '0;
        end else if (clr) begin
            edge_sticky <= d_edge;
            edge_cnt    <= d_edge ? CNT_W'(1) : '0;
        end else if (d_edge) begin
            edge_sticky <= 1'b1;
            if (edge_cnt != CNT_MAX) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_edge_monitor.sv
// Multi-channel RX line edge monitor (ch0 = D+, ch1 = D-).
//   clk, n_rst   : clock, asynchronous active-low reset
//   d_in         : raw asynchronous line inputs, one per channel
//   edge_mode    : per-channel mode, bits [2i+1:2i] = channel i
//   clr          : per-channel write-1-to-clear for sticky and count
//   filt_out     : synchronized, glitch-filtered levels
//   d_edge       : per-channel one-cycle qualified edge pulses
//   any_edge     : OR of all d_edge bits
//   edge_sticky  : per-channel sticky edge flags
//   edge_cnt     : per-channel counts, channel i in [(i+1)*CNT_W-1:i*CNT_W]
module rx_edge_monitor
    import rx_edge_pkg::*;
#(
    parameter int unsigned       NUM_CH      = DEF_NUM_CH,
    parameter int unsigned       SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned       FILT_CYCLES = DEF_FILT_CYCLES,
    parameter int unsigned       CNT_W       = DEF_CNT_W,
    parameter logic [NUM_CH-1:0] IDLE_VAL    = NUM_CH'(DEF_IDLE_VAL)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       d_in,
    input  logic [2*NUM_CH-1:0]     edge_mode,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       filt_out,
    output logic [NUM_CH-1:0]       d_edge,
    output logic                    any_edge,
    output logic [NUM_CH-1:0]       edge_sticky,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rx_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .CNT_W       (CNT_W),
            .IDLE_BIT    (IDLE_VAL[i])
        ) u_chan (
            .clk         (clk),
            .n_rst       (n_rst),
            .d_in        (d_in[i]),
            .edge_mode   (edge_mode[2*i+1:2*i]),
            .clr         (clr[i]),
            .filt_out    (filt_out[i]),
            .d_edge      (d_edge[i]),
            .edge_sticky (edge_sticky[i]),
            .edge_cnt    (edge_cnt[(i+1)*CNT_W-1:i*CNT_W])
        );
    end

    assign any_edge = |d_edge;

endmodule

// File: tb/tb_rx_edge_monitor.sv
module tb_rx_edge_monitor;

    localparam int NCH  = 2;
    localparam int SYNC = 2;
    localparam int FC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = 15;
    localparam logic [1:0] IDLE = 2'b01;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [1:0]     d_in;
    logic [3:0]     edge_mode;
    logic [1:0]     clr;
    logic [1:0]     filt_out;
    logic [1:0]     d_edge;
    logic           any_edge;
    logic [1:0]     edge_sticky;
    logic [2*CW-1:0] edge_cnt;

    rx_edge_monitor #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (SYNC),
        .FILT_CYCLES (FC),
        .CNT_W       (CW),
        .IDLE_VAL    (IDLE)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .d_in        (d_in),
        .edge_mode   (edge_mode),
        .clr         (clr),
        .filt_out    (filt_out),
        .d_edge      (d_edge),
        .any_edge    (any_edge),
        .edge_sticky (edge_sticky),
        .edge_cnt    (edge_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Filtered level flips when the last FC sampled synchronizer values all
    // disagree with it; sampled history is forgotten on reset.
    logic [1:0] din_q[$];   // d_in values sampled at recent edges (oldest first)
    logic [1:0] samp_q[$];  // synchronizer outputs seen by the filter
    logic [1:0] m_filt, m_prev, m_sticky;
    int         m_cnt[2];

    typedef struct packed {
        logic [1:0] filt;
        logic [1:0] de;
        logic       any;
        logic [1:0] sticky;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [1:0] qual(input logic [3:0] mode,
                                        input logic [1:0] cur,
                                        input logic [1:0] old);
        logic [1:0] r;
        r = '0;
        for (int c = 0; c < 2; c++) begin
            int md;
            md = int'(mode[2*c +: 2]);
            if (cur[c] != old[c]) begin
                if (md == 3) r[c] = 1'b1;
                else if (md == 1 && cur[c] == 1'b1) r[c] = 1'b1;
                else if (md == 2 && cur[c] == 1'b0) r[c] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        din_q.delete();
        for (int s = 0; s < SYNC; s++) din_q.push_back(IDLE);
        samp_q.delete();
        m_filt   = IDLE;
        m_prev   = IDLE;
        m_sticky = '0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic model_edge();
        logic [1:0] de, nf;
        if (!n_rst) begin
            model_reset();
            return;
        end
        de = qual(edge_mode, m_filt, m_prev);
        for (int c = 0; c < 2; c++) begin
            if (clr[c]) begin
                m_sticky[c] = de[c];
                m_cnt[c]    = de[c] ? 1 : 0;
            end else if (de[c]) begin
                m_sticky[c] = 1'b1;
                if (m_cnt[c] < CMAX) m_cnt[c]++;
            end
        end
        samp_q.push_back(din_q[0]);
        if (samp_q.size() > FC) void'(samp_q.pop_front());
        nf = m_filt;
        for (int c = 0; c < 2; c++) begin
            if (samp_q.size() == FC) begin
                bit all_diff;
                all_diff = 1'b1;
                foreach (samp_q[k]) if (samp_q[k][c] == m_filt[c]) all_diff = 1'b0;
                if (all_diff) nf[c] = ~m_filt[c];
            end
        end
        m_prev = m_filt;
        m_filt = nf;
        din_q.push_back(d_in);
        void'(din_q.pop_front());
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        model_edge();
    endtask

    task automatic setin(input logic [1:0] din, input logic [3:0] mode,
                         input logic [1:0] c, input logic rst);
        exp_t e;
        d_in      = din;
        edge_mode = mode;
        clr       = c;
        n_rst     = rst;
        if (!rst) model_reset();
        e.filt   = m_filt;
        e.de     = rst ? qual(mode, m_filt, m_prev) : 2'b00;
        e.any    = |e.de;
        e.sticky = m_sticky;
        e.cnt    = {m_cnt[1][3:0], m_cnt[0][3:0]};
        sb_q.push_back(e);
    endtask

    task automatic cyc(input int n, input logic [1:0] din, input logic [3:0] mode,
                       input logic [1:0] c);
        for (int k = 0; k < n; k++) begin
            tick();
            setin(din, mode, (k == 0) ? c : 2'b00, 1'b1);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("filt_out",    {6'd0, filt_out},    {6'd0, e.filt});
            chk("d_edge",      {6'd0, d_edge},      {6'd0, e.de});
            chk("any_edge",    {7'd0, any_edge},    {7'd0, e.any});
            chk("edge_sticky", {6'd0, edge_sticky}, {6'd0, e.sticky});
            chk("edge_cnt",    edge_cnt,            e.cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        n_rst = 1'b0; d_in = IDLE; edge_mode = 4'hF; clr = 2'b00;

        // reset held, then released at idle: no edges expected
        for (int k = 0; k < 3; k++) begin tick(); setin(IDLE, 4'hF, 2'b00, 1'b0); end
        cyc(10, 2'b01, 4'hF, 2'b00);

        // ch0 falls, any-edge mode
        cyc(10, 2'b00, 4'hF, 2'b00);
        cyc(10, 2'b01, 4'hF, 2'b11);

        // 2-cycle glitch is filtered, 3-cycle glitch gives fall + rise
        cyc(1, 2'b01, 4'hF, 2'b11);
        cyc(2, 2'b00, 4'hF, 2'b00);
        cyc(10, 2'b01, 4'hF, 2'b00);
        cyc(3, 2'b00, 4'hF, 2'b00);
        cyc(10, 2'b01, 4'hF, 2'b00);

        // ch1 rise-only, then off: level still toggles
        for (int t = 0; t < 4; t++) cyc(7, {~t[0], 1'b1}, 4'h7, 2'b00);
        for (int t = 0; t < 4; t++) cyc(7, {~t[0], 1'b1}, 4'h3, 2'b00);
        cyc(3, 2'b01, 4'hF, 2'b11);

        // saturation on ch0 after 20 edges, then clear
        for (int t = 0; t < 20; t++) cyc(6, {1'b0, t[0]}, 4'hF, 2'b00);
        cyc(6, 2'b01, 4'hF, 2'b00);
        cyc(4, 2'b01, 4'hF, 2'b11);

        // simultaneous edges on both channels with clr aligned to predicted edges
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 6; k++) begin
                logic [1:0] din;
                din = t[0] ? 2'b10 : 2'b01;
                tick();
                setin(din, 4'hF, qual(4'hF, m_filt, m_prev), 1'b1);
            end
        end
        cyc(6, 2'b01, 4'hF, 2'b00);

        // reset mid-filter, released at idle
        cyc(4, 2'b00, 4'hF, 2'b00);
        tick(); setin(IDLE, 4'hF, 2'b00, 1'b0);
        tick(); setin(IDLE, 4'hF, 2'b00, 1'b0);
        cyc(10, 2'b01, 4'hF, 2'b00);

        // randomized traffic: random hold lengths straddle the filter threshold
        for (int b = 0; b < 120; b++) begin
            logic [1:0] din;
            logic [3:0] mode;
            logic [1:0] c;
            int         n;
            din  = 2'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? 4'($urandom) : edge_mode;
            c    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            n    = $urandom_range(1, 6);
            cyc(n, din, mode, c);
        end
        cyc(8, 2'b01, 4'hF, 2'b00);

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
